// File: rtl/mem_pkg.sv
/******************************************************************************
 * Module   : mem_pkg
 * Brief    : Shared types and constants for the pipelined data memory.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

  localparam int MAX_READ_LATENCY = 4;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
/******************************************************************************
 * Module   : mem_lane_align
 * Brief    : Byte-lane enables, store data replication, load extraction and
 *            sign/zero extension, misalignment detection (combinational).
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  input  logic        i_unsigned,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_byte_en    = 4'b0000;
    o_wdata      = i_wdata;
    o_rdata      = 32'd0;
    o_misaligned = 1'b0;
    case (i_size)
      SIZE_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_misaligned = i_addr_lo[0];
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        o_misaligned = (i_addr_lo != 2'b00);
        o_byte_en    = 4'b1111;
        o_rdata      = i_rword;
      end
      default: o_misaligned = 1'b1;
    endcase
    // A faulting access must neither write nor return data.
    if (o_misaligned) begin
      o_byte_en = 4'b0000;
      o_rdata   = 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_data_memory.sv
/******************************************************************************
 * Module   : pipelined_data_memory
 * Brief    : Load/store data memory with post-reset clear engine and a
 *            fixed-latency in-order response pipeline.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module pipelined_data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int                c_wa_w      = ADDR_WIDTH - 2;
  localparam int                c_depth     = 2 ** c_wa_w;
  localparam logic [c_wa_w-1:0] c_last_word = '1;
  localparam logic [c_wa_w-1:0] c_wa_one    = 1;

  mem_state_t        r_state, w_state_nxt;
  logic [c_wa_w-1:0] r_clr_cnt;
  logic [31:0]       r_mem [c_depth];

  logic              w_accept, w_clearing, w_req_err;
  logic [c_wa_w-1:0] w_waddr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_unused_req_rdata;

  assign req_ready  = reset_n && (r_state == ST_READY);
  assign busy       = (r_state == ST_CLEAR);
  assign w_accept   = req_valid && req_ready;
  assign w_clearing = reset_n && (r_state == ST_CLEAR);
  assign w_waddr    = req_addr[ADDR_WIDTH-1:2];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET != 0) r_state <= ST_CLEAR;
      else                     r_state <= ST_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_cnt == c_last_word) w_state_nxt = ST_READY;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                  r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR)  r_clr_cnt <= r_clr_cnt + c_wa_one;
  end

  mem_lane_align u_req_align (
    .i_size       (req_size),
    .i_addr_lo    (req_addr[1:0]),
    .i_wdata      (req_wdata),
    .i_rword      (32'd0),
    .i_unsigned   (1'b0),
    .o_byte_en    (w_be),
    .o_wdata      (w_wdata_sh),
    .o_rdata      (w_unused_req_rdata),
    .o_misaligned (w_req_err)
  );

  // Stores commit at the accept edge so a load in the next cycle sees them.
  always_ff @(posedge clock) begin
    if (w_clearing) begin
      r_mem[r_clr_cnt] <= 32'd0;
    end else if (w_accept && req_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  logic        r_s1_valid, r_s1_load, r_s1_err, r_s1_uns;
  logic [1:0]  r_s1_size, r_s1_addr_lo;
  logic [31:0] r_s1_rword;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_load    <= 1'b0;
      r_s1_err     <= 1'b0;
      r_s1_uns     <= 1'b0;
      r_s1_size    <= 2'd0;
      r_s1_addr_lo <= 2'd0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_load    <= !req_write && !w_req_err;
        r_s1_err     <= w_req_err;
        r_s1_uns     <= req_unsigned;
        r_s1_size    <= req_size;
        r_s1_addr_lo <= req_addr[1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_s1_rword <= r_mem[w_waddr];
  end

  logic [31:0] w_s1_ext, w_unused_rsp_wdata;
  logic [3:0]  w_unused_rsp_be;
  logic        w_unused_rsp_mis;

  mem_lane_align u_rsp_align (
    .i_size       (r_s1_size),
    .i_addr_lo    (r_s1_addr_lo),
    .i_wdata      (32'd0),
    .i_rword      (r_s1_rword),
    .i_unsigned   (r_s1_uns),
    .o_byte_en    (w_unused_rsp_be),
    .o_wdata      (w_unused_rsp_wdata),
    .o_rdata      (w_s1_ext),
    .o_misaligned (w_unused_rsp_mis)
  );

  logic [READ_LATENCY-1:0] w_pv, w_pe;
  logic [31:0]             w_pd [READ_LATENCY];

  assign w_pv[0] = r_s1_valid;
  assign w_pe[0] = r_s1_err;
  assign w_pd[0] = r_s1_load ? w_s1_ext : 32'd0;

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_delay
    logic        r_v, r_e;
    logic [31:0] r_d;
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_v <= 1'b0;
        r_e <= 1'b0;
        r_d <= 32'd0;
      end else begin
        r_v <= w_pv[gi-1];
        r_e <= w_pe[gi-1];
        r_d <= w_pd[gi-1];
      end
    end
    assign w_pv[gi] = r_v;
    assign w_pe[gi] = r_e;
    assign w_pd[gi] = r_d;
  end

  assign rsp_valid = w_pv[READ_LATENCY-1];
  assign rsp_error = w_pe[READ_LATENCY-1];
  assign rsp_rdata = w_pd[READ_LATENCY-1];

endmodule

`default_nettype wire
